// File: rtl/sequence_checker.sv
// -----------------------------------------------------------------------------
// sequence_checker
//
// Receive-side checker for the 8-byte repeating test pattern
// AF, BC, E2, 78, FF, E2, 0B, 8D. AF is the sync byte and is unique in the
// table. The checker hunts for AF, locks onto the pattern phase, and then
// compares every valid byte against the expected byte for that phase.
//
// Parameters:
//   ERR_W        width of err_count   (saturates at all-ones)
//   FRM_W        width of frame_count (saturates at all-ones)
//   LOSS_THRESH  consecutive mismatches in LOCKED that drop lock (1..15)
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   valid        qualifies data (one beat per cycle with valid=1)
//   data         byte under test
//   clear        synchronous clear of counters and FSM; beats are ignored
//   locked       high while in LOCKED
//   err          one-cycle pulse per mismatched beat while LOCKED
//   frame_ok     one-cycle pulse when a frame of 8 beats had no mismatch
//   err_count    saturating mismatch count
//   frame_count  saturating count of frame_ok pulses
// -----------------------------------------------------------------------------
module sequence_checker #(
    parameter int ERR_W       = 16,
    parameter int FRM_W       = 16,
    parameter int LOSS_THRESH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [7:0]       data,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic             frame_ok,
    output logic [ERR_W-1:0] err_count,
    output logic [FRM_W-1:0] frame_count
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hAF;
    localparam logic [3:0] LOSS_LIMIT = 4'(LOSS_THRESH);

    state_t             state_reg;
    logic [2:0]         idx_reg;
    logic [3:0]         miss_reg;
    logic               frame_bad_reg;
    logic               err_reg;
    logic               frame_ok_reg;
    logic [ERR_W-1:0]   err_count_reg;
    logic [FRM_W-1:0]   frame_count_reg;

    function automatic logic [7:0] expected_byte(input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = 8'hAF;
            3'd1:    b = 8'hBC;
            3'd2:    b = 8'hE2;
            3'd3:    b = 8'h78;
            3'd4:    b = 8'hFF;
            3'd5:    b = 8'hE2;
            3'd6:    b = 8'h0B;
            default: b = 8'h8D;
        endcase
        return b;
    endfunction

    logic       beat_match;
    logic [3:0] miss_inc;
    logic       lose_lock;
    logic       frame_end;

    assign beat_match = (data == expected_byte(idx_reg));
    assign miss_inc   = miss_reg + 4'd1;
    // Lock is lost on the beat whose mismatch brings the run length to the limit.
    assign lose_lock  = !beat_match && (miss_inc == LOSS_LIMIT);
    assign frame_end  = (idx_reg == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= HUNT;
            idx_reg         <= 3'd0;
            miss_reg        <= 4'd0;
            frame_bad_reg   <= 1'b0;
            err_reg         <= 1'b0;
            frame_ok_reg    <= 1'b0;
            err_count_reg   <= '0;
            frame_count_reg <= '0;
        end else begin
            // Pulses are low unless this cycle's beat raises them.
            err_reg      <= 1'b0;
            frame_ok_reg <= 1'b0;

            if (clear) begin
                state_reg       <= HUNT;
                idx_reg         <= 3'd0;
                miss_reg        <= 4'd0;
                frame_bad_reg   <= 1'b0;
                err_count_reg   <= '0;
                frame_count_reg <= '0;
            end else if (valid) begin
                case (state_reg)
                    HUNT: begin
                        // The AF that achieves lock is beat 0 of the first frame.
                        if (data == SYNC_BYTE) begin
                            state_reg     <= LOCKED;
                            idx_reg       <= 3'd1;
                            miss_reg      <= 4'd0;
                            frame_bad_reg <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        // Phase advances on every beat so single errors keep alignment.
                        idx_reg <= idx_reg + 3'd1;
                        if (beat_match) begin
                            miss_reg <= 4'd0;
                        end else begin
                            err_reg       <= 1'b1;
                            miss_reg      <= miss_inc;
                            frame_bad_reg <= 1'b1;
                            if (!(&err_count_reg))
                                err_count_reg <= err_count_reg + ERR_W'(1);
                        end

                        if (frame_end) begin
                            // Later assignment wins: next frame starts clean.
                            frame_bad_reg <= 1'b0;
                            if (beat_match && !frame_bad_reg) begin
                                frame_ok_reg <= 1'b1;
                                if (!(&frame_count_reg))
                                    frame_count_reg <= frame_count_reg + FRM_W'(1);
                            end
                        end

                        if (lose_lock) begin
                            state_reg <= HUNT;
                            idx_reg   <= 3'd0;
                            miss_reg  <= 4'd0;
                        end
                    end
                    default: state_reg <= HUNT;
                endcase
            end
        end
    end

    assign locked      = (state_reg == LOCKED);
    assign err         = err_reg;
    assign frame_ok    = frame_ok_reg;
    assign err_count   = err_count_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_sequence_checker.sv
module tb_sequence_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: default parameters (LOSS_THRESH=3, 16-bit counters)
    logic        reset_n;
    logic        valid;
    logic        clear;
    logic [7:0]  data;
    logic        locked;
    logic        err;
    logic        frame_ok;
    logic [15:0] err_count;
    logic [15:0] frame_count;

    // Second DUT: narrow error counter and long loss threshold
    logic        valid2;
    logic        clear2;
    logic [7:0]  data2;
    logic        locked2;
    logic        err2;
    logic        frame_ok2;
    logic [3:0]  err_count2;
    logic [15:0] frame_count2;

    sequence_checker dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid       (valid),
        .data        (data),
        .clear       (clear),
        .locked      (locked),
        .err         (err),
        .frame_ok    (frame_ok),
        .err_count   (err_count),
        .frame_count (frame_count)
    );

    sequence_checker #(.ERR_W(4), .FRM_W(16), .LOSS_THRESH(15)) dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid       (valid2),
        .data        (data2),
        .clear       (clear2),
        .locked      (locked2),
        .err         (err2),
        .frame_ok    (frame_ok2),
        .err_count   (err_count2),
        .frame_count (frame_count2)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] pat [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

    typedef struct packed {
        logic        locked;
        logic        err;
        logic        frame_ok;
        logic [15:0] err_count;
        logic [15:0] frame_count;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model state for the main DUT
    logic m_locked;
    logic m_bad;
    logic m_err;
    logic m_fok;
    int   m_idx;
    int   m_miss;
    int   m_errc;
    int   m_frmc;

    int obs_err;
    int obs_fok;

    task automatic model_reset();
        m_locked = 1'b0; m_bad = 1'b0; m_err = 1'b0; m_fok = 1'b0;
        m_idx = 0; m_miss = 0; m_errc = 0; m_frmc = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
        logic hit;
        m_err = 1'b0;
        m_fok = 1'b0;
        if (clr) begin
            model_reset();
        end else if (v) begin
            if (!m_locked) begin
                if (d == 8'hAF) begin
                    m_locked = 1'b1; m_idx = 1; m_miss = 0; m_bad = 1'b0;
                end
            end else begin
                hit = (d == pat[m_idx]);
                if (hit) m_miss = 0;
                else begin
                    m_err = 1'b1;
                    m_miss = m_miss + 1;
                    if (m_errc < 65535) m_errc = m_errc + 1;
                end
                if (m_idx == 7) begin
                    if (hit && !m_bad) begin
                        m_fok = 1'b1;
                        if (m_frmc < 65535) m_frmc = m_frmc + 1;
                    end
                    m_bad = 1'b0;
                end else if (!hit) begin
                    m_bad = 1'b1;
                end
                m_idx = (m_idx + 1) % 8;
                if (m_miss == 3) begin
                    m_locked = 1'b0; m_idx = 0; m_miss = 0;
                end
            end
        end
    endtask

    // Drive one cycle on the main DUT; the expected outcome goes to the scoreboard.
    task automatic drive(input logic v, input logic [7:0] d, input logic clr);
        exp_t e;
        @(negedge clk);
        valid = v; data = d; clear = clr;
        model_step(v, d, clr);
        e.locked = m_locked; e.err = m_err; e.frame_ok = m_fok;
        e.err_count = 16'(m_errc); e.frame_count = 16'(m_frmc);
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic send_pattern(input int start, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) drive(1'b0, 8'h00, 1'b0);
            end
            drive(1'b1, pat[(start + k) % 8], 1'b0);
        end
    endtask

    // Scoreboard: compares each registered response one cycle after its beat.
    always @(posedge clk) begin
        #1;
        if (err) obs_err = obs_err + 1;
        if (frame_ok) obs_fok = obs_fok + 1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checks = checks + 5;
            if (locked !== mon_e.locked) begin
                failures++; $display("FAIL sb_locked t=%0t got=%b exp=%b", $time, locked, mon_e.locked);
            end
            if (err !== mon_e.err) begin
                failures++; $display("FAIL sb_err t=%0t got=%b exp=%b", $time, err, mon_e.err);
            end
            if (frame_ok !== mon_e.frame_ok) begin
                failures++; $display("FAIL sb_frame_ok t=%0t got=%b exp=%b", $time, frame_ok, mon_e.frame_ok);
            end
            if (err_count !== mon_e.err_count) begin
                failures++; $display("FAIL sb_err_count t=%0t got=%0d exp=%0d", $time, err_count, mon_e.err_count);
            end
            if (frame_count !== mon_e.frame_count) begin
                failures++; $display("FAIL sb_frame_count t=%0t got=%0d exp=%0d", $time, frame_count, mon_e.frame_count);
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; valid = 1'b0; clear = 1'b0; data = 8'h00;
        valid2 = 1'b0; clear2 = 1'b0; data2 = 8'h00;
        model_reset();
        obs_err = 0; obs_fok = 0;
        #12;
        checks++;
        if ({locked, err, frame_ok, err_count, frame_count} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%b/%0d/%0d exp=0/0/0/0/0", locked, err, frame_ok, err_count, frame_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_clean();
        obs_err = 0; obs_fok = 0;
        drive(1'b1, 8'hAF, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL clean_lock got=%b exp=1", locked);
        end
        send_pattern(1, 31, 1'b0);
        checks += 3;
        if (frame_count !== 16'd4) begin
            failures++; $display("FAIL clean_frame_count got=%0d exp=4", frame_count);
        end
        if (err_count !== 16'd0) begin
            failures++; $display("FAIL clean_err_count got=%0d exp=0", err_count);
        end
        if (obs_fok != 4) begin
            failures++; $display("FAIL clean_fok_pulses got=%0d exp=4", obs_fok);
        end
        $display("test_clean done frames=%0d", frame_count);
    endtask

    task automatic test_single_err();
        drive(1'b0, 8'h00, 1'b1);
        obs_err = 0; obs_fok = 0;
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, (k == 11) ? 8'h00 : pat[k % 8], 1'b0);
            if (k == 15) begin
                checks++;
                if (frame_ok !== 1'b0) begin
                    failures++; $display("FAIL single_frame2_ok got=%b exp=0", frame_ok);
                end
            end
            if (k == 23) begin
                checks++;
                if (frame_ok !== 1'b1) begin
                    failures++; $display("FAIL single_frame3_ok got=%b exp=1", frame_ok);
                end
            end
        end
        checks += 4;
        if (obs_err != 1) begin
            failures++; $display("FAIL single_err_pulses got=%0d exp=1", obs_err);
        end
        if (err_count !== 16'd1) begin
            failures++; $display("FAIL single_err_count got=%0d exp=1", err_count);
        end
        if (locked !== 1'b1) begin
            failures++; $display("FAIL single_locked got=%b exp=1", locked);
        end
        if (frame_count !== 16'd3) begin
            failures++; $display("FAIL single_frame_count got=%0d exp=3", frame_count);
        end
        $display("test_single_err done errs=%0d", err_count);
    endtask

    task automatic test_loss();
        drive(1'b0, 8'h00, 1'b1);
        obs_err = 0; obs_fok = 0;
        send_pattern(0, 8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h00, 1'b0);
            checks += 2;
            if (err !== 1'b1) begin
                failures++; $display("FAIL loss_err_%0d got=%b exp=1", k, err);
            end
            if (locked !== (k < 2)) begin
                failures++; $display("FAIL loss_locked_%0d got=%b exp=%b", k, locked, (k < 2));
            end
        end
        send_pattern(3, 5, 1'b0);
        send_pattern(0, 8, 1'b0);
        checks += 4;
        if (obs_err != 3) begin
            failures++; $display("FAIL loss_err_pulses got=%0d exp=3", obs_err);
        end
        if (frame_ok !== 1'b1) begin
            failures++; $display("FAIL loss_relock_fok got=%b exp=1", frame_ok);
        end
        if (frame_count !== 16'd2) begin
            failures++; $display("FAIL loss_frame_count got=%0d exp=2", frame_count);
        end
        if (err_count !== 16'd3) begin
            failures++; $display("FAIL loss_err_count got=%0d exp=3", err_count);
        end
        $display("test_loss done");
    endtask

    task automatic test_gaps();
        drive(1'b0, 8'h00, 1'b1);
        obs_err = 0; obs_fok = 0;
        send_pattern(2, 6, 1'b1);
        checks += 2;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL gaps_prelock got=%b exp=0", locked);
        end
        if (obs_err != 0) begin
            failures++; $display("FAIL gaps_prelock_err got=%0d exp=0", obs_err);
        end
        send_pattern(0, 24, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        checks += 2;
        if (obs_fok != 3) begin
            failures++; $display("FAIL gaps_fok_pulses got=%0d exp=3", obs_fok);
        end
        if (err_count !== 16'd0) begin
            failures++; $display("FAIL gaps_err_count got=%0d exp=0", err_count);
        end
        $display("test_gaps done frames=%0d", frame_count);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        valid = 1'b0; clear = 1'b0;
        clear2 = 1'b1; valid2 = 1'b0;
        @(negedge clk);
        clear2 = 1'b0; valid2 = 1'b1; data2 = 8'hAF;
        @(posedge clk); #2;
        checks++;
        if (locked2 !== 1'b1) begin
            failures++; $display("FAIL sat_lock got=%b exp=1", locked2);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            data2 = 8'h55;
            @(posedge clk); #2;
            checks += 3;
            if (err_count2 !== 4'((k > 15) ? 15 : k)) begin
                failures++; $display("FAIL sat_count_%0d got=%0d exp=%0d", k, err_count2, (k > 15) ? 15 : k);
            end
            if (locked2 !== (k < 15)) begin
                failures++; $display("FAIL sat_locked_%0d got=%b exp=%b", k, locked2, (k < 15));
            end
            if (err2 !== (k <= 15)) begin
                failures++; $display("FAIL sat_err_%0d got=%b exp=%b", k, err2, (k <= 15));
            end
        end
        @(negedge clk);
        data2 = 8'hAF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            data2 = 8'h55;
            @(posedge clk); #2;
            checks += 3;
            if (err_count2 !== 4'd15) begin
                failures++; $display("FAIL sat_hold_%0d got=%0d exp=15", k, err_count2);
            end
            if (err2 !== 1'b1) begin
                failures++; $display("FAIL sat_hold_err_%0d got=%b exp=1", k, err2);
            end
            if (locked2 !== 1'b1) begin
                failures++; $display("FAIL sat_hold_locked_%0d got=%b exp=1", k, locked2);
            end
        end
        @(negedge clk);
        valid2 = 1'b0;
        $display("test_saturation done count=%0d", err_count2);
    endtask

    task automatic test_clear_reset();
        drive(1'b0, 8'h00, 1'b1);
        send_pattern(0, 4, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        // clear with a beat in the same cycle: the beat is ignored
        drive(1'b1, 8'hAF, 1'b1);
        checks += 3;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL clear_locked got=%b exp=0", locked);
        end
        if (err_count !== 16'd0) begin
            failures++; $display("FAIL clear_err_count got=%0d exp=0", err_count);
        end
        if (frame_count !== 16'd0) begin
            failures++; $display("FAIL clear_frame_count got=%0d exp=0", frame_count);
        end
        send_pattern(0, 8, 1'b0);
        checks++;
        if (frame_count !== 16'd1) begin
            failures++; $display("FAIL clear_relock_frames got=%0d exp=1", frame_count);
        end
        send_pattern(0, 5, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({locked, err, frame_ok, err_count, frame_count} !== 35'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b/%b/%b/%0d/%0d exp=0/0/0/0/0", locked, err, frame_ok, err_count, frame_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        send_pattern(3, 3, 1'b0);
        send_pattern(0, 8, 1'b0);
        checks += 2;
        if (frame_count !== 16'd1) begin
            failures++; $display("FAIL reset_relock_frames got=%0d exp=1", frame_count);
        end
        if (locked !== 1'b1) begin
            failures++; $display("FAIL reset_relock_locked got=%b exp=1", locked);
        end
        $display("test_clear_reset done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean();
        test_single_err();
        test_loss();
        test_gaps();
        test_saturation();
        test_clear_reset();
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
